// File: rtl/rst_seq01_if.sv
// ============================================================================
//  Module   : rst_seq01_if
//  Purpose  : Request/configuration/status bundle of the reset sequencer.
//             The master drives the requests and the configuration; the
//             slave (the sequencer) drives the domain resets and the status.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rst_seq01_if #(
  parameter int NDOM = 4,
  parameter int CNTW = 8
);
  logic            swrst_req;
  logic            wdt_expire;
  logic [CNTW-1:0] stretch_len;
  logic [CNTW-1:0] rel_gap;
  logic [NDOM-1:0] orst_;
  logic            busy;
  logic            swrst_ack;
  logic [1:0]      rst_cause;

  modport master (
    output swrst_req, wdt_expire, stretch_len, rel_gap,
    input  orst_, busy, swrst_ack, rst_cause
  );

  modport slave (
    input  swrst_req, wdt_expire, stretch_len, rel_gap,
    output orst_, busy, swrst_ack, rst_cause
  );
endinterface

`default_nettype wire

// File: rtl/rst_seq01.sv
// ============================================================================
//  Module   : rst_seq01
//  Purpose  : Reset sequencer. Holds all domain resets low for a stretch
//             phase, then releases the active-low domain resets one at a
//             time, in index order, separated by a programmable gap.
//             Sequences start at power-on (rst), on a software request or on
//             a watchdog expiry; the watchdog outranks software.
//  Options  : RSTSEQ_CAUSE_EN - when defined, a rst_cause register records
//             the origin of the last sequence; otherwise rst_cause reads 00
//             and a single pending bit tracks software sequences for the ack.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq01 #(
  parameter int NDOM = 4,
  parameter int CNTW = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  rst_seq01_if.slave     bus
);

  localparam int IW = (NDOM > 1) ? $clog2(NDOM) : 1;

  localparam logic [1:0]    c_ST_IDLE    = 2'd0;
  localparam logic [1:0]    c_ST_ASSERT  = 2'd1;
  localparam logic [1:0]    c_ST_RELEASE = 2'd2;
  localparam logic [1:0]    c_CAUSE_POR  = 2'b00;
  localparam logic [IW-1:0] c_IDX_LAST   = IW'(NDOM - 1);

  logic [1:0]      r_state;
  logic [CNTW-1:0] r_cnt;
  logic [IW-1:0]   r_idx;
  logic [NDOM-1:0] r_orst;
  logic [CNTW-1:0] r_stretch;
  logic [CNTW-1:0] r_gap;
  logic            r_ack;
  logic            w_req;
  logic            w_sw_seq;

  assign w_req = bus.swrst_req | bus.wdt_expire;

  // Sequencer FSM: any request (re)enters ASSERT, otherwise step the phases.
  // The counter only counts up to the latched limit, so it never wraps even
  // when the limit is the all-ones value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_ST_ASSERT;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_orst    <= '0;
      r_ack     <= 1'b0;
      r_stretch <= bus.stretch_len;
      r_gap     <= bus.rel_gap;
    end else begin
      r_ack <= 1'b0;
      if (w_req) begin
        r_state   <= c_ST_ASSERT;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_orst    <= '0;
        r_stretch <= bus.stretch_len;
        r_gap     <= bus.rel_gap;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            r_cnt <= '0;
          end
          c_ST_ASSERT: begin
            if (r_cnt == r_stretch) begin
              r_state <= c_ST_RELEASE;
              r_cnt   <= '0;
              r_idx   <= '0;
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
          c_ST_RELEASE: begin
            if (r_cnt == r_gap) begin
              r_orst[r_idx] <= 1'b1;
              r_cnt         <= '0;
              if (r_idx == c_IDX_LAST) begin
                r_state <= c_ST_IDLE;
                r_idx   <= '0;
                r_ack   <= w_sw_seq;
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef RSTSEQ_CAUSE_EN
  localparam logic [1:0] c_CAUSE_SW  = 2'b01;
  localparam logic [1:0] c_CAUSE_WDT = 2'b10;

  logic [1:0] r_cause;

  // Record the origin of each sequence on ASSERT entry; watchdog wins a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause <= c_CAUSE_POR;
    end else if (bus.wdt_expire) begin
      r_cause <= c_CAUSE_WDT;
    end else if (bus.swrst_req) begin
      r_cause <= c_CAUSE_SW;
    end
  end

  assign w_sw_seq      = (r_cause == c_CAUSE_SW);
  assign bus.rst_cause = r_cause;
`else
  logic r_sw_pend;

  // Remember whether the running sequence was started by software alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_pend <= 1'b0;
    end else if (bus.wdt_expire) begin
      r_sw_pend <= 1'b0;
    end else if (bus.swrst_req) begin
      r_sw_pend <= 1'b1;
    end
  end

  assign w_sw_seq      = r_sw_pend;
  assign bus.rst_cause = c_CAUSE_POR;
`endif

  assign bus.orst_     = r_orst;
  assign bus.busy      = (r_state != c_ST_IDLE);
  assign bus.swrst_ack = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq01.sv
// ============================================================================
//  Module   : tb_rst_seq01
//  Purpose  : Directed bench for rst_seq01 (NDOM=4, CNTW=8). Expected domain
//             release cycles come from the closed-form schedule
//             release(i) = (S+1) + (i+1)*(G+1), counted from the first
//             ASSERT cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq01;

  localparam int NDOM = 4;
  localparam int CNTW = 8;

`ifdef RSTSEQ_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  rst_seq01_if #(.NDOM(NDOM), .CNTW(CNTW)) bus ();

  rst_seq01 #(.NDOM(NDOM), .CNTW(CNTW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] cause_exp(input logic [1:0] c);
    return CAUSE_ON ? c : 2'b00;
  endfunction

  // Issue a one-cycle request with a new configuration; returns at ASSERT k=0.
  task automatic req(input bit sw, input bit wdt, input int s, input int g);
    bus.stretch_len = CNTW'(s);
    bus.rel_gap     = CNTW'(g);
    bus.swrst_req   = sw;
    bus.wdt_expire  = wdt;
    tick();
    bus.swrst_req   = 1'b0;
    bus.wdt_expire  = 1'b0;
  endtask

  // Check every cycle of a sequence from ASSERT k=0 up to kmax (or IDLE entry).
  // At cycle kchg the configuration inputs are disturbed.
  task automatic run_seq(input string tag, input int s, input int g, input bit sw,
                         input int kmax, input int kchg);
    int r_last;
    int kend;
    logic [NDOM-1:0] bits;
    r_last = (s + 1) + NDOM * (g + 1);
    kend   = (kmax < 0 || kmax > r_last) ? r_last : kmax;
    for (int k = 0; k <= kend; k++) begin
      bits = '0;
      for (int i = 0; i < NDOM; i++)
        if (k >= (s + 1) + (i + 1) * (g + 1)) bits[i] = 1'b1;
      check($sformatf("%s orst k=%0d", tag, k), 32'(bus.orst_), 32'(bits));
      check($sformatf("%s busy k=%0d", tag, k), 32'(bus.busy), 32'(k < r_last));
      check($sformatf("%s ack k=%0d", tag, k), 32'(bus.swrst_ack), 32'(sw && k == r_last));
      if (k == kchg) begin
        bus.stretch_len = 8'd0;
        bus.rel_gap     = 8'd0;
      end
      if (k < kend) tick();
    end
  endtask

  // One cycle after IDLE entry: ack gone, all released, cause as expected.
  task automatic post_seq(input string tag, input logic [1:0] c);
    tick();
    check({tag, " ack_after"}, 32'(bus.swrst_ack), 32'd0);
    check({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, " orst_after"}, 32'(bus.orst_), 32'hF);
    check({tag, " cause"}, 32'(bus.rst_cause), 32'(cause_exp(c)));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.swrst_req   = 1'b0;
    bus.wdt_expire  = 1'b0;
    bus.stretch_len = 8'd3;
    bus.rel_gap     = 8'd2;

    // Reset values
    repeat (3) tick();
    check("rst orst", 32'(bus.orst_), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd1);
    check("rst ack", 32'(bus.swrst_ack), 32'd0);
    check("rst cause", 32'(bus.rst_cause), 32'd0);

    // Power-on sequence: bits at 7,10,13,16, busy falls at 16
    rst = 1'b0;
    run_seq("por", 3, 2, 1'b0, -1, -1);
    post_seq("por", 2'b00);
    repeat (3) tick();
    check("idle busy", 32'(bus.busy), 32'd0);

    // Software sequence with minimal phases
    req(1'b1, 1'b0, 0, 0);
    run_seq("sw", 0, 0, 1'b1, -1, -1);
    post_seq("sw", 2'b01);

    // Simultaneous requests: watchdog wins, no ack
    req(1'b1, 1'b1, 1, 1);
    run_seq("both", 1, 1, 1'b0, -1, -1);
    post_seq("both", 2'b10);

    // Software sequence aborted by watchdog after domain 1 is released
    req(1'b1, 1'b0, 2, 1);
    run_seq("abt_sw", 2, 1, 1'b1, 7, -1);
    check("abt orst_pre", 32'(bus.orst_), 32'h3);
    req(1'b0, 1'b1, 2, 1);
    run_seq("abt_wdt", 2, 1, 1'b0, -1, -1);
    post_seq("abt", 2'b10);

    // Request during ASSERT restarts the counter with new configuration
    req(1'b1, 1'b0, 5, 0);
    run_seq("rst_a", 5, 0, 1'b1, 3, -1);
    req(1'b1, 1'b0, 2, 0);
    run_seq("rst_b", 2, 0, 1'b1, -1, -1);
    post_seq("rst_b", 2'b01);

    // Maximum stretch: ASSERT lasts 256 cycles
    req(1'b1, 1'b0, 255, 0);
    run_seq("max", 255, 0, 1'b1, -1, -1);
    post_seq("max", 2'b01);

    // Reconfiguration during RELEASE has no effect on the running sequence
    req(1'b1, 1'b0, 1, 3);
    run_seq("recfg", 1, 3, 1'b1, -1, 8);
    post_seq("recfg", 2'b01);

    // rst pulsed mid-RELEASE: back to reset values, power-on sequence reruns
    req(1'b1, 1'b0, 1, 1);
    run_seq("mid", 1, 1, 1'b1, 5, -1);
    check("mid orst_pre", 32'(bus.orst_), 32'h1);
    bus.stretch_len = 8'd3;
    bus.rel_gap     = 8'd2;
    rst = 1'b1;
    tick();
    check("mid rst orst", 32'(bus.orst_), 32'd0);
    check("mid rst busy", 32'(bus.busy), 32'd1);
    check("mid rst ack", 32'(bus.swrst_ack), 32'd0);
    check("mid rst cause", 32'(bus.rst_cause), 32'd0);
    rst = 1'b0;
    run_seq("por2", 3, 2, 1'b0, -1, -1);
    post_seq("por2", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
